// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift/rotate register with a counted burst engine
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] op;
  logic [2:0] sel;
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] nq;
  logic nsout;
  logic shift;
  // next value of q/sout for one step of the active operation (latched op while bursting)
  always_comb begin
    sel = (state == BUSY) ? op : mode;
    shift = (sel >= 3'd2) && (sel <= 3'd6);
    nq = q;
    nsout = sout;
    case (sel)
      3'd1: nq = d;
      3'd2: begin nq = {q[WIDTH-2:0], sin};      nsout = q[WIDTH-1]; end
      3'd3: begin nq = {sin, q[WIDTH-1:1]};      nsout = q[0];       end
      3'd4: begin nq = {q[WIDTH-2:0], q[WIDTH-1]}; nsout = q[WIDTH-1]; end
      3'd5: begin nq = {q[0], q[WIDTH-1:1]};     nsout = q[0];       end
      3'd6: begin nq = {q[WIDTH-1], q[WIDTH-1:1]}; nsout = q[0];     end
      3'd7: nq = RST_VAL;
      default: nq = q;
    endcase
  end
  // register update and burst FSM; done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      sout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      op <= 3'd0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (state == IDLE) begin
          if (start && shift && amt != '0) begin
            op <= mode;
            cnt <= amt;
            state <= BUSY;
            busy <= 1'b1;
          end else if (start && shift) begin
            done <= 1'b1;
          end else begin
            q <= nq;
            sout <= nsout;
          end
        end else begin
          q <= nq;
          sout <= nsout;
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule
